rgb_matrix_scanner: RTL and testbench
=====================================

# rgb_matrix_scanner

Row-multiplexing display driver for the 5x5 RGB LED matrix. Consumes the 25-bit R/G/B frame vectors produced by the pattern shifter directly upstream and drives the matrix row selects and active-low colour column lines. It adds inter-row blanking against ghosting and a 16-level global brightness control.

## Interface
Parameters:
- SLOT_CYCLES, 64: clocks per brightness slot; must be ≥1.
- BLANK_CYCLES, 8: dead-time clocks before each row is lit; must be ≥1.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- R  in  25  red frame; bit index = row*5 + col, with row and col in 0..4.
- G  in  25  green frame, same mapping.
- B  in  25  blue frame, same mapping.
- brightness  in  4  global duty: 0 = dark, 15 = 15/16.
- row  out  5  one-hot row select, active-high.
- col_r_n  out  5  red column sinks, active-low (0 = LED on).
- col_g_n  out  5  green column sinks, active-low.
- col_b_n  out  5  blue column sinks, active-low.
- frame_start  out  1  one-cycle pulse on the first cycle of each frame.

## Operation
- State registers:
  - row_idx: 0..4.
  - phase: BLANK or ON.
  - cycle counter.
  - slot counter: 0..15.
  - latched brightness.
- BLANK:
  - row = 0; all columns = 5'h1F.
  - Lasts BLANK_CYCLES clocks, then go to ON with slot = 0.
  - brightness is sampled on the last BLANK cycle and held for the whole ON phase.
- ON:
  - row[row_idx] = 1.
  - Lasts 16*SLOT_CYCLES clocks; the slot counter advances every SLOT_CYCLES clocks.
  - When slot < latched brightness: col_x_n[c] = ~buf_X[row_idx*5+c].
  - Otherwise all columns are 5'h1F.
  - The row select stays asserted for the whole ON phase, including dark slots.
- After the last ON cycle, row_idx increments and the block enters BLANK. Row 4 wraps to row 0.
- frame_start = 1 exactly on the first BLANK cycle of row 0.
- All outputs are decoded from registers only. No combinational path runs from R/G/B or brightness to any output.
- Row period = BLANK_CYCLES + 16*SLOT_CYCLES. Frame period = 5 × row period.

## Timing
- Reset (any cycle, including mid-row):
  - row_idx = 0, phase = BLANK, counters = 0, frame buffers = 0.
  - Outputs during reset: row = 0, col_*_n = 5'h1F, frame_start = 0.
- First cycle after reset release:
  - Block is in BLANK of row 0, so frame_start = 1.
  - First lit cycle is BLANK_CYCLES clocks after release.
- Frame buffer load (with FRAME_LATCH_EN): R/G/B present in the frame_start cycle are captured on that clock edge. They are displayed from row 0's ON phase onward. Input changes at any other time have no effect until the next frame_start.
- Brightness changes take effect at the next row boundary, never within a row.
- Make-before-break is never allowed. Between any two lit rows there are ≥ BLANK_CYCLES clocks with row = 0.

## Configuration
- RGB_SCANNER_FRAME_LATCH_EN defined:
  - 75-bit frame buffer loaded only at frame_start.
  - Tear-free display.
- RGB_SCANNER_FRAME_LATCH_EN undefined:
  - No buffer. R/G/B are registered every clock (one-cycle pipeline) and used directly.
  - Input changes appear on the column outputs 1 clock later, even mid-row.
  - frame_start behaviour is unchanged.

## Test plan
All scenarios use SLOT_CYCLES = 4 and BLANK_CYCLES = 2, giving a 66-clock row and a 330-clock frame.
- Reset release with R = 25'h1, G = B = 0, brightness = 15:
  - frame_start = 1 at cycle 0; row = 0 for cycles 0–1.
  - row = 5'b00001 from cycle 2.
  - col_r_n = 5'b11110 for cycles 2–61, then 5'h1F for cycles 62–65; col_g_n = col_b_n = 5'h1F throughout.
- Full scan with R = G = B = 25'h1FFFFFF, brightness = 15:
  - row walks 00001 → 10000, each row lit 64 clocks after 2 blank clocks.
  - The next frame_start comes exactly 330 clocks after the previous one.
- brightness = 0:
  - Rows still scan.
  - All col_*_n stay 5'h1F forever.
- brightness = 4:
  - In each row, columns are active for 16 clocks, then 5'h1F for 48 clocks.
  - A change to 8 mid-row takes effect from the next row only.
- FRAME_LATCH_EN, changing R from 25'h1F to 25'h0 at clock 100:
  - Row 0 data stays 5'b00000 on col_r_n until the frame ends.
  - col_r_n is all 1s after the next frame_start; with the macro off, it changes at clock 101.
- Reset asserted at clock 150 (during row 2 ON):
  - Next cycle: row = 0, columns = 5'h1F.
  - After release, the sequence restarts from row 0 with frame_start = 1.

Source files
------------

// File: rtl/rgb_matrix_scanner.sv
// Row-multiplexed driver for a 5x5 RGB LED matrix with inter-row blanking and 16-level brightness.
// Optional macro RGB_SCANNER_FRAME_LATCH_EN: tear-free 75-bit frame buffer loaded only at frame_start.
module rgb_matrix_scanner #(
    parameter int SLOT_CYCLES  = 64,
    parameter int BLANK_CYCLES = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [24:0] R,
    input  logic [24:0] G,
    input  logic [24:0] B,
    input  logic [3:0]  brightness,
    output logic [4:0]  row,
    output logic [4:0]  col_r_n,
    output logic [4:0]  col_g_n,
    output logic [4:0]  col_b_n,
    output logic        frame_start
);
    localparam int MAX_CYCLES = (SLOT_CYCLES > BLANK_CYCLES) ? SLOT_CYCLES : BLANK_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES) + 1;
    localparam logic [CW-1:0] SLOT_LAST  = CW'(SLOT_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

    typedef enum logic {BLANK, ON} phase_t;

    phase_t        phase_reg, phase_next;
    logic [2:0]    row_idx_reg, row_idx_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [3:0]    slot_reg, slot_next;
    logic [3:0]    bright_reg, bright_next;
    logic          run_reg;
    logic [24:0]   buf_r_reg, buf_g_reg, buf_b_reg;
    logic          frame_start_int;

    logic [4:0] red_rows [5];
    logic [4:0] grn_rows [5];
    logic [4:0] blu_rows [5];
    logic [4:0] row_onehot;

    // run_reg holds the sequencer for one clock after reset so that the first
    // released cycle is the frame_start cycle of row 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase_reg   <= BLANK;
            row_idx_reg <= 3'd0;
            cnt_reg     <= '0;
            slot_reg    <= 4'd0;
            bright_reg  <= 4'd0;
            run_reg     <= 1'b0;
        end else begin
            run_reg <= 1'b1;
            if (run_reg) begin
                phase_reg   <= phase_next;
                row_idx_reg <= row_idx_next;
                cnt_reg     <= cnt_next;
                slot_reg    <= slot_next;
                bright_reg  <= bright_next;
            end
        end
    end

    always_comb begin
        phase_next   = phase_reg;
        row_idx_next = row_idx_reg;
        cnt_next     = cnt_reg + CW'(1);
        slot_next    = slot_reg;
        bright_next  = bright_reg;
        case (phase_reg)
            BLANK: begin
                if (cnt_reg == BLANK_LAST) begin
                    phase_next  = ON;
                    cnt_next    = '0;
                    slot_next   = 4'd0;
                    bright_next = brightness;
                end
            end
            ON: begin
                if (cnt_reg == SLOT_LAST) begin
                    cnt_next = '0;
                    if (slot_reg == 4'd15) begin
                        phase_next   = BLANK;
                        row_idx_next = (row_idx_reg == 3'd4) ? 3'd0 : row_idx_reg + 3'd1;
                    end else begin
                        slot_next = slot_reg + 4'd1;
                    end
                end
            end
            default: ;
        endcase
    end

    assign frame_start_int = run_reg && (phase_reg == BLANK) && (row_idx_reg == 3'd0) && (cnt_reg == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            buf_r_reg <= '0;
            buf_g_reg <= '0;
            buf_b_reg <= '0;
        end
`ifdef RGB_SCANNER_FRAME_LATCH_EN
        else if (frame_start_int) begin
`else
        else begin
`endif
            buf_r_reg <= R;
            buf_g_reg <= G;
            buf_b_reg <= B;
        end
    end

    for (genvar gi = 0; gi < 5; gi++) begin : g_slice
        assign red_rows[gi]   = buf_r_reg[gi*5 +: 5];
        assign grn_rows[gi]   = buf_g_reg[gi*5 +: 5];
        assign blu_rows[gi]   = buf_b_reg[gi*5 +: 5];
        assign row_onehot[gi] = (row_idx_reg == 3'(gi));
    end

    // Row stays selected through dark slots; only the column sinks are gated.
    always_comb begin
        row         = 5'd0;
        col_r_n     = 5'h1F;
        col_g_n     = 5'h1F;
        col_b_n     = 5'h1F;
        frame_start = frame_start_int;
        if (phase_reg == ON) begin
            row = row_onehot;
            if (slot_reg < bright_reg) begin
                col_r_n = ~red_rows[row_idx_reg];
                col_g_n = ~grn_rows[row_idx_reg];
                col_b_n = ~blu_rows[row_idx_reg];
            end
        end
    end
endmodule

// File: tb/tb_rgb_matrix_scanner.sv
// Scoreboard bench for rgb_matrix_scanner (SLOT_CYCLES=4, BLANK_CYCLES=2: 66-clock row, 330-clock frame).
// Follows RGB_SCANNER_FRAME_LATCH_EN the same way the design does.
module tb_rgb_matrix_scanner;
    localparam int SLOT  = 4;
    localparam int BLANK = 2;
    localparam int ROWP  = BLANK + 16 * SLOT;
    localparam int FRAME = 5 * ROWP;
`ifdef RGB_SCANNER_FRAME_LATCH_EN
    localparam bit LATCH = 1'b1;
`else
    localparam bit LATCH = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [24:0] R = '0, G = '0, B = '0;
    logic [3:0]  brightness = 4'd0;
    logic [4:0]  row, col_r_n, col_g_n, col_b_n;
    logic        frame_start;

    rgb_matrix_scanner #(.SLOT_CYCLES(SLOT), .BLANK_CYCLES(BLANK)) dut (
        .clk(clk), .reset(reset), .R(R), .G(G), .B(B), .brightness(brightness),
        .row(row), .col_r_n(col_r_n), .col_g_n(col_g_n), .col_b_n(col_b_n),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    int          vec_n = 0;
    int          err_n = 0;
    logic [20:0] sb [$];
    logic [20:0] obs, expv;

    // Behavioural model: position in the frame is derived from elapsed cycles.
    int          m_t = -1;
    logic [3:0]  m_bl = 4'd0;
    logic [24:0] m_r = '0, m_g = '0, m_b = '0;

    task automatic tick();
        int rt, ri;
        logic [4:0] rv, cr, cg, cb;
        logic fs;
        if (reset) begin
            m_t = -1; m_bl = 4'd0; m_r = '0; m_g = '0; m_b = '0;
        end else begin
            if (!LATCH || (m_t >= 0 && m_t % FRAME == 0)) begin
                m_r = R; m_g = G; m_b = B;
            end
            if (m_t >= 0 && m_t % ROWP == BLANK - 1) m_bl = brightness;
            m_t++;
        end
        rv = 5'd0; cr = 5'h1F; cg = 5'h1F; cb = 5'h1F; fs = 1'b0;
        if (m_t >= 0) begin
            rt = m_t % ROWP;
            ri = (m_t / ROWP) % 5;
            fs = (m_t % FRAME == 0);
            if (rt >= BLANK) begin
                rv = 5'(1 << ri);
                if ((rt - BLANK) / SLOT < int'(m_bl)) begin
                    cr = ~m_r[ri*5 +: 5]; cg = ~m_g[ri*5 +: 5]; cb = ~m_b[ri*5 +: 5];
                end
            end
        end
        sb.push_back({rv, cr, cg, cb, fs});
        @(posedge clk);
        @(negedge clk);
        obs  = {row, col_r_n, col_g_n, col_b_n, frame_start};
        expv = sb.pop_front();
        vec_n++;
        if (obs !== expv) begin
            err_n++;
            $display("FAIL scoreboard t=%0d: got row=%b r=%b g=%b b=%b fs=%b, want row=%b r=%b g=%b b=%b fs=%b",
                     m_t, obs[20:16], obs[15:11], obs[10:6], obs[5:1], obs[0],
                     expv[20:16], expv[15:11], expv[10:6], expv[5:1], expv[0]);
        end
    endtask

    task automatic wait_fs();
        bit found = 1'b0;
        for (int k = 0; k < FRAME + 10 && !found; k++) begin
            tick();
            if (frame_start === 1'b1) found = 1'b1;
        end
        vec_n++;
        if (!found) begin
            err_n++;
            $display("FAIL wait_fs: got no frame_start, want one within %0d clocks", FRAME + 10);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; R = 25'h1; G = '0; B = '0; brightness = 4'd15;
        repeat (3) begin
            tick();
            vec_n++;
            if (obs !== {5'd0, 5'h1F, 5'h1F, 5'h1F, 1'b0}) begin
                err_n++;
                $display("FAIL reset_outputs: got %h, want %h", obs, {5'd0, 5'h1F, 5'h1F, 5'h1F, 1'b0});
            end
        end
        $display("test_reset: done");
    endtask

    task automatic test_first_row();
        logic [19:0] want;
        reset = 1'b0;
        for (int c = 0; c < ROWP; c++) begin
            tick();
            want = {(c < 2) ? 5'd0 : 5'b00001, (c >= 2 && c <= 61) ? 5'b11110 : 5'h1F, 5'h1F, 5'h1F};
            vec_n++;
            if (obs[20:1] !== want || obs[0] !== (c == 0)) begin
                err_n++;
                $display("FAIL first_row c=%0d: got %h fs=%b, want %h fs=%b", c, obs[20:1], obs[0], want, c == 0);
            end
        end
        $display("test_first_row: done");
    endtask

    task automatic test_full_scan();
        int last_fs = -1, zero_run = 0, lit_run = 0;
        bit counting = 1'b0;
        logic [4:0] prev_lit = 5'd0;
        R = 25'h1FFFFFF; G = 25'h1FFFFFF; B = 25'h1FFFFFF; brightness = 4'd15;
        for (int c = 0; c < 700; c++) begin
            tick();
            if (frame_start === 1'b1) begin
                if (last_fs >= 0) begin
                    vec_n++;
                    if (c - last_fs != FRAME) begin
                        err_n++;
                        $display("FAIL frame_period: got %0d, want %0d", c - last_fs, FRAME);
                    end
                end
                last_fs = c;
            end
            if (row == 5'd0) begin
                if (lit_run > 0) begin
                    if (counting) begin
                        vec_n++;
                        if (lit_run != 16 * SLOT) begin
                            err_n++;
                            $display("FAIL lit_length: got %0d, want %0d", lit_run, 16 * SLOT);
                        end
                    end
                    counting = 1'b1;
                    lit_run = 0;
                end
                zero_run++;
            end else begin
                if (lit_run == 0) begin
                    if (prev_lit != 5'd0) begin
                        vec_n++;
                        if (zero_run < BLANK || row !== {prev_lit[3:0], prev_lit[4]}) begin
                            err_n++;
                            $display("FAIL row_walk: got row=%b after %0d blank, want row=%b after >=%0d blank",
                                     row, zero_run, {prev_lit[3:0], prev_lit[4]}, BLANK);
                        end
                    end
                    prev_lit = row;
                    zero_run = 0;
                end
                lit_run++;
            end
        end
        $display("test_full_scan: done");
    endtask

    task automatic test_brightness_zero();
        brightness = 4'd0;
        repeat (ROWP) tick();
        for (int c = 0; c < FRAME; c++) begin
            tick();
            vec_n++;
            if ({col_r_n, col_g_n, col_b_n} !== 15'h7FFF) begin
                err_n++;
                $display("FAIL dark_columns: got %b %b %b, want all ones", col_r_n, col_g_n, col_b_n);
            end
        end
        $display("test_brightness_zero: done");
    endtask

    task automatic test_brightness_four();
        int act;
        int want [3] = '{16, 16, 32};
        brightness = 4'd4;
        wait_fs();
        for (int j = 0; j < 3; j++) begin
            act = 0;
            for (int k = 0; k < ROWP; k++) begin
                if (j == 1 && k == 30) brightness = 4'd8;
                tick();
                if (col_r_n != 5'h1F) act++;
            end
            vec_n++;
            if (act != want[j]) begin
                err_n++;
                $display("FAIL active_clocks row%0d: got %0d, want %0d", j, act, want[j]);
            end
        end
        $display("test_brightness_four: done");
    endtask

    task automatic test_frame_latch(input int change_at);
        logic [4:0] want;
        R = 25'h1F; G = '0; B = '0; brightness = 4'd15;
        wait_fs();
        for (int c = 0; c < 341; c++) begin
            if (c == change_at) R = 25'h0;
            tick();
            if (c + 1 >= 2 && c + 1 <= 61) begin
                want = (LATCH || c + 1 <= change_at) ? 5'b00000 : 5'h1F;
                vec_n++;
                if (col_r_n !== want) begin
                    err_n++;
                    $display("FAIL latch_row0 c=%0d: got %b, want %b", c + 1, col_r_n, want);
                end
            end
            if (c + 1 == FRAME + 10) begin
                vec_n++;
                if (col_r_n !== 5'h1F) begin
                    err_n++;
                    $display("FAIL next_frame_r: got %b, want 11111", col_r_n);
                end
            end
        end
        $display("test_frame_latch(%0d): done", change_at);
    endtask

    task automatic test_reset_mid_row();
        R = 25'h1FFFFFF; brightness = 4'd15;
        wait_fs();
        repeat (150) tick();
        vec_n++;
        if (row !== 5'b00100) begin
            err_n++;
            $display("FAIL row2_before_reset: got %b, want 00100", row);
        end
        reset = 1'b1;
        repeat (3) begin
            tick();
            vec_n++;
            if (obs !== {5'd0, 5'h1F, 5'h1F, 5'h1F, 1'b0}) begin
                err_n++;
                $display("FAIL mid_reset_outputs: got %h, want %h", obs, {5'd0, 5'h1F, 5'h1F, 5'h1F, 1'b0});
            end
        end
        reset = 1'b0;
        tick();
        vec_n++;
        if (frame_start !== 1'b1 || row !== 5'd0) begin
            err_n++;
            $display("FAIL restart: got fs=%b row=%b, want fs=1 row=00000", frame_start, row);
        end
        repeat (2) tick();
        vec_n++;
        if (row !== 5'b00001) begin
            err_n++;
            $display("FAIL restart_row0: got %b, want 00001", row);
        end
        $display("test_reset_mid_row: done");
    endtask

    initial begin
        test_reset();
        test_first_row();
        test_full_scan();
        test_brightness_zero();
        test_brightness_four();
        test_frame_latch(100);
        test_frame_latch(30);
        test_reset_mid_row();
        $display("== %0d vectors applied, %0d miscompares ==", vec_n, err_n);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, want finish before 1ms");
        $fatal(1, "watchdog expired");
    end
endmodule
